// File: rtl/axi4_burst_master_pkg.sv
// axi4_burst_master_pkg: FSM states and fixed AXI encodings shared by the burst self-test master
package axi4_burst_master_pkg;
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FIN} state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] AxSIZE_4B = 3'b010;
  localparam logic [3:0] AxCACHE_DEFAULT = 4'b0011;
endpackage

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: writes C_NUM_BURSTS INCR bursts of an incrementing pattern, reads them back and checks every beat
module axi4_burst_master
  import axi4_burst_master_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_ID_WIDTH = 1,
  parameter int unsigned C_BURST_LEN = 8,
  parameter int unsigned C_NUM_BURSTS = 4,
  parameter logic [C_ADDR_WIDTH-1:0] C_TARGET_BASE = '0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERROR,
  output logic [C_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                M_AXI_AWLEN,
  output logic [2:0]                M_AXI_AWSIZE,
  output logic [1:0]                M_AXI_AWBURST,
  output logic                      M_AXI_AWLOCK,
  output logic [3:0]                M_AXI_AWCACHE,
  output logic [2:0]                M_AXI_AWPROT,
  output logic [3:0]                M_AXI_AWQOS,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WLAST,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [C_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                M_AXI_ARLEN,
  output logic [2:0]                M_AXI_ARSIZE,
  output logic [1:0]                M_AXI_ARBURST,
  output logic                      M_AXI_ARLOCK,
  output logic [3:0]                M_AXI_ARCACHE,
  output logic [2:0]                M_AXI_ARPROT,
  output logic [3:0]                M_AXI_ARQOS,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RLAST,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);
  localparam logic [7:0] LAST_BEAT = 8'(C_BURST_LEN - 1);
  localparam logic [3:0] LAST_BURST = 4'(C_NUM_BURSTS - 1);
  localparam logic [C_ADDR_WIDTH-1:0] STRIDE = C_ADDR_WIDTH'(C_BURST_LEN * 4);
  localparam logic [31:0] LEN32 = 32'(C_BURST_LEN);
  state_e state_q, state_d;
  logic [7:0] beat_q, beat_d;
  logic [3:0] burst_q, burst_d;
  logic err_q, err_d, done_q, done_d, busy_q;
  logic awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_DATA_WIDTH-1:0] wdata_q;
  logic unused_ids;
  function automatic logic [C_DATA_WIDTH-1:0] pattern(input logic [3:0] bu, input logic [7:0] be);
    return C_DATA_WIDTH'(LEN32 * 32'(bu) + 32'(be) + 32'd1);
  endfunction
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    burst_d = burst_q;
    err_d = err_q;
    done_d = done_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = AW;
        beat_d = '0;
        burst_d = '0;
        err_d = 1'b0;
        done_d = 1'b0;
      end
      AW: state_d = M_AXI_AWREADY ? W : AW;
      W: if (M_AXI_WREADY) begin
        beat_d = beat_q == LAST_BEAT ? '0 : beat_q + 8'd1;
        state_d = beat_q == LAST_BEAT ? B : W;
      end
      B: if (M_AXI_BVALID) begin
        err_d = err_q | (M_AXI_BRESP != RESP_OKAY);
        burst_d = burst_q == LAST_BURST ? '0 : burst_q + 4'd1;
        state_d = burst_q == LAST_BURST ? AR : AW;
      end
      AR: state_d = M_AXI_ARREADY ? R : AR;
      // burst end is counted locally so a bad RLAST only flags ERROR
      R: if (M_AXI_RVALID) begin
        err_d = err_q | (M_AXI_RDATA != pattern(burst_q, beat_q)) | (M_AXI_RRESP != RESP_OKAY)
              | (M_AXI_RLAST != (beat_q == LAST_BEAT));
        beat_d = beat_q == LAST_BEAT ? '0 : beat_q + 8'd1;
        if (beat_q == LAST_BEAT) begin
          burst_d = burst_q == LAST_BURST ? burst_q : burst_q + 4'd1;
          state_d = burst_q == LAST_BURST ? FIN : AR;
          done_d = burst_q == LAST_BURST;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      beat_q <= '0;
      burst_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      wlast_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      burst_q <= burst_d;
      err_q <= err_d;
      done_q <= done_d;
      busy_q <= state_d != IDLE && state_d != FIN;
      awvalid_q <= state_d == AW;
      wvalid_q <= state_d == W;
      wlast_q <= state_d == W && beat_d == LAST_BEAT;
      bready_q <= state_d == B;
      arvalid_q <= state_d == AR;
      rready_q <= state_d == R;
      addr_q <= C_TARGET_BASE + STRIDE * C_ADDR_WIDTH'(burst_d);
      wdata_q <= pattern(burst_d, beat_d);
    end
  end
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERROR = err_q;
  assign M_AXI_AWID = '0;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_AWLEN = LAST_BEAT;
  assign M_AXI_AWSIZE = AxSIZE_4B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK = 1'b0;
  assign M_AXI_AWCACHE = AxCACHE_DEFAULT;
  assign M_AXI_AWPROT = '0;
  assign M_AXI_AWQOS = '0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA = wdata_q;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_WLAST = wlast_q;
  assign M_AXI_WVALID = wvalid_q;
  assign M_AXI_BREADY = bready_q;
  assign M_AXI_ARID = '0;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_ARLEN = LAST_BEAT;
  assign M_AXI_ARSIZE = AxSIZE_4B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK = 1'b0;
  assign M_AXI_ARCACHE = AxCACHE_DEFAULT;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_ARQOS = '0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY = rready_q;
  assign unused_ids = ^{M_AXI_BID, M_AXI_RID};
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: scoreboard bench driving the burst master against a behavioural AXI slave
module tb_axi4_burst_master;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic busy, done, error, busy1, done1, error1;
  logic [0:0] awid, arid, bid = '0, rid = '0, awid1, arid1;
  logic [31:0] awaddr, araddr, wdata, awaddr1, araddr1, wdata1;
  logic [31:0] rdata = '0, rdata1 = '0;
  logic [7:0] awlen, arlen, awlen1, arlen1;
  logic [2:0] awsize, arsize, awprot, arprot, awsize1, arsize1, awprot1, arprot1;
  logic [1:0] awburst, arburst, awburst1, arburst1;
  logic [1:0] bresp = '0, rresp = '0;
  logic [3:0] awcache, arcache, awqos, arqos, wstrb, awcache1, arcache1, awqos1, arqos1, wstrb1;
  logic awlock, arlock, awlock1, arlock1;
  logic awvalid, wvalid, wlast, bready, arvalid, rready;
  logic awvalid1, wvalid1, wlast1, bready1, arvalid1, rready1;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic bvalid1 = 1'b0, rvalid1 = 1'b0, rlast1 = 1'b0;

  axi4_burst_master u_dut (
    .ACLK(clk), .ARESET(rst), .START(start), .BUSY(busy), .DONE(done), .ERROR(error),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  axi4_burst_master #(.C_BURST_LEN(1), .C_NUM_BURSTS(1)) u_dut1 (
    .ACLK(clk), .ARESET(rst), .START(start1), .BUSY(busy1), .DONE(done1), .ERROR(error1),
    .M_AXI_AWID(awid1), .M_AXI_AWADDR(awaddr1), .M_AXI_AWLEN(awlen1), .M_AXI_AWSIZE(awsize1),
    .M_AXI_AWBURST(awburst1), .M_AXI_AWLOCK(awlock1), .M_AXI_AWCACHE(awcache1), .M_AXI_AWPROT(awprot1),
    .M_AXI_AWQOS(awqos1), .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(1'b1),
    .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WLAST(wlast1), .M_AXI_WVALID(wvalid1), .M_AXI_WREADY(1'b1),
    .M_AXI_BID(bid), .M_AXI_BRESP(2'b00), .M_AXI_BVALID(bvalid1), .M_AXI_BREADY(bready1),
    .M_AXI_ARID(arid1), .M_AXI_ARADDR(araddr1), .M_AXI_ARLEN(arlen1), .M_AXI_ARSIZE(arsize1),
    .M_AXI_ARBURST(arburst1), .M_AXI_ARLOCK(arlock1), .M_AXI_ARCACHE(arcache1), .M_AXI_ARPROT(arprot1),
    .M_AXI_ARQOS(arqos1), .M_AXI_ARVALID(arvalid1), .M_AXI_ARREADY(1'b1),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata1), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(rlast1),
    .M_AXI_RVALID(rvalid1), .M_AXI_RREADY(rready1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  logic [31:0] aw_q[$], ar_q[$];
  logic [32:0] w_q[$];
  logic [1:0] res_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] waddr = '0, raddr = '0, aw_sv = '0, ar_sv = '0, mem1 = '0;
  logic [32:0] w_sv = '0;
  int wbeat = 0, rbeat = 0, wr_burst = 0, rd_burst = 0, err_burst = -1;
  bit stall = 0, corrupt = 0, b_pend = 0, b_err = 0, r_active = 0, r_hold = 0, err_next = 0;
  bit aw_st = 0, w_st = 0, ar_st = 0, b1_pend = 0, r1_pend = 0;

  // Inputs are driven at the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge clk) if (!rst) begin
    if (err_next) chk("error after SLVERR", 64'(error), 64'(1));
    err_next = 0;
    if (aw_st) chk("aw stable while stalled", 64'({awvalid, awaddr}), 64'({1'b1, aw_sv}));
    if (w_st) chk("w stable while stalled", 64'({wvalid, w_sv}), 64'({1'b1, wlast, wdata}));
    if (ar_st) chk("ar stable while stalled", 64'({arvalid, araddr}), 64'({1'b1, ar_sv}));
    awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    bvalid = b_pend;
    bresp = b_err ? 2'b10 : 2'b00;
    rvalid = r_active && (r_hold || !stall || $urandom_range(0, 1) == 1);
    rdata = (corrupt && rd_burst == 0 && rbeat == 5) ? 32'h0 : mem[6'(raddr[7:2] + 6'(rbeat))];
    rlast = rbeat == 7;
    aw_st = awvalid && !awready;
    aw_sv = awaddr;
    if (awvalid && awready) begin
      chk("aw expected", 64'(aw_q.size() != 0), 64'(1));
      if (aw_q.size() != 0) chk("awaddr", 64'(awaddr), 64'(aw_q.pop_front()));
      waddr = awaddr;
      wbeat = 0;
    end
    w_st = wvalid && !wready;
    w_sv = {wlast, wdata};
    if (wvalid && wready) begin
      chk("w expected", 64'(w_q.size() != 0), 64'(1));
      if (w_q.size() != 0) chk("wlast/wdata", 64'({wlast, wdata}), 64'(w_q.pop_front()));
      mem[6'(waddr[7:2] + 6'(wbeat))] = wdata;
      wbeat++;
      if (wbeat == 8) begin
        b_pend = 1;
        b_err = wr_burst == err_burst;
        wr_burst++;
      end
    end
    if (bvalid && bready) begin
      b_pend = 0;
      err_next = b_err;
    end
    ar_st = arvalid && !arready;
    ar_sv = araddr;
    if (arvalid && arready) begin
      chk("ar expected", 64'(ar_q.size() != 0), 64'(1));
      if (ar_q.size() != 0) chk("araddr", 64'(araddr), 64'(ar_q.pop_front()));
      raddr = araddr;
      rbeat = 0;
      r_active = 1;
    end
    if (rvalid && rready) begin
      rbeat++;
      r_hold = 0;
      if (rbeat == 8) begin
        r_active = 0;
        rd_burst++;
      end
    end else r_hold = rvalid;
  end

  // Zero-wait slave for the single-beat instance.
  always @(negedge clk) if (!rst) begin
    bvalid1 = b1_pend;
    rvalid1 = r1_pend;
    rdata1 = mem1;
    rlast1 = 1'b1;
    if (awvalid1) chk("bl1 awaddr", 64'(awaddr1), 64'(0));
    if (wvalid1) begin
      chk("bl1 wlast/wdata", 64'({wlast1, wdata1}), 64'({1'b1, 32'h1}));
      mem1 = wdata1;
      b1_pend = 1;
    end
    if (bvalid1 && bready1) b1_pend = 0;
    if (arvalid1) begin
      chk("bl1 araddr", 64'(araddr1), 64'(0));
      r1_pend = 1;
    end
    if (rvalid1 && rready1) r1_pend = 0;
  end

  task automatic start_run(input bit st, input int eb, input bit co, input bit exp_err);
    stall = st;
    err_burst = eb;
    corrupt = co;
    wr_burst = 0;
    rd_burst = 0;
    for (int b = 0; b < 4; b++) begin
      aw_q.push_back(32'(b * 32));
      ar_q.push_back(32'(b * 32));
      for (int i = 0; i < 8; i++) w_q.push_back({i == 7, 32'(b * 8 + i + 1)});
    end
    res_q.push_back({1'b1, exp_err});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy/awvalid/done/error after start", 64'({busy, awvalid, done, error}), 64'(4'b1100));
  endtask

  task automatic wait_done(input bit fin_start);
    int n = 0;
    logic [1:0] want;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done before timeout", 64'(done), 64'(1));
    chk("result expected", 64'(res_q.size() != 0), 64'(1));
    want = res_q.size() != 0 ? res_q.pop_front() : 2'b00;
    chk("done/error/busy at FIN", 64'({done, error, busy}), 64'({want, 1'b0}));
    chk("all transfers issued", 64'(aw_q.size() + w_q.size() + ar_q.size()), 64'(0));
    if (fin_start) begin
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("start in FIN ignored", 64'({busy, awvalid, done}), 64'(3'b001));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset controls", 64'({awvalid, wvalid, bready, arvalid, rready, wlast, busy, done, error}), 64'(0));
    chk("reset addr/data", 64'({awaddr, wdata}), 64'(0));
    @(negedge clk) rst = 1'b0;
    chk("tied aw/w", 64'({awlen, awsize, awburst, awcache, awlock, awprot, awqos, wstrb, awid}),
        64'({8'd7, 3'b010, 2'b01, 4'b0011, 1'b0, 3'b0, 4'b0, 4'hF, 1'b0}));
    chk("tied ar", 64'({arlen, arsize, arburst, arcache, arlock, arprot, arqos, arid}),
        64'({8'd7, 3'b010, 2'b01, 4'b0011, 1'b0, 3'b0, 4'b0, 1'b0}));
    start_run(0, -1, 0, 0);
    wait_done(1);
    chk("mem[31] written", 64'(mem[31]), 64'(32));
    start_run(1, -1, 0, 0);
    wait_done(0);
    start_run(0, 2, 0, 1);
    wait_done(0);
    start_run(0, -1, 1, 1);
    wait_done(0);
    start_run(0, -1, 0, 0);
    wait_done(0);
    start_run(1, -1, 0, 0);
    n = 0;
    while (!wvalid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached W", 64'(wvalid), 64'(1));
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start during W ignored", 64'({busy, done}), 64'(2'b10));
    n = 0;
    while (!rready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reached R", 64'(rready), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async reset controls", 64'({awvalid, wvalid, bready, arvalid, rready, wlast, busy, done, error}), 64'(0));
    chk("async reset addr/data", 64'({araddr, wdata}), 64'(0));
    aw_q.delete();
    w_q.delete();
    ar_q.delete();
    res_q.delete();
    {b_pend, r_active, r_hold, err_next, aw_st, w_st, ar_st} = '0;
    {bvalid, rvalid} = '0;
    @(negedge clk) rst = 1'b0;
    start_run(0, -1, 0, 0);
    wait_done(0);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    n = 0;
    while (!done1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bl1 done/error", 64'({done1, error1, busy1}), 64'(3'b100));
    chk("bl1 readback", 64'(mem1), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
